// File: rtl/cpu_io_ports.sv
// CPU I/O port block: per-channel sampled input ports behind a read mux, and a
// FIFO-buffered output port with valid/ready handshake and a sticky overflow flag.
module cpu_io_ports #(
  parameter int WIDTH = 16,
  parameter int NIN   = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NIN*WIDTH-1:0]       p_in,
  input  logic [$clog2(NIN)-1:0]     rd_sel,
  output logic [WIDTH-1:0]           rd_data,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       wr_full,
  output logic [WIDTH-1:0]           salida,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] samp_r [NIN];
  logic [WIDTH-1:0] mem_r  [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic             full_r;
  logic             valid_r;
  logic             overflow_r;
  logic [WIDTH-1:0] salida_r;
  logic [WIDTH-1:0] salida_next_s;
  logic [WIDTH-1:0] rd_data_s;
  logic             push_s;
  logic             pop_s;
  logic             drop_s;

  // Per-channel input sample registers, refreshed every clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NIN; k++) samp_r[k] <= {WIDTH{1'b0}};
    end else begin
      for (int k = 0; k < NIN; k++) samp_r[k] <= p_in[k*WIDTH +: WIDTH];
    end
  end

  // CPU read mux over the sample registers; unpopulated selectors read zero.
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    if (int'(rd_sel) < NIN) begin
      rd_data_s = samp_r[rd_sel];
    end else begin
      rd_data_s = {WIDTH{1'b0}};
    end
  end

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign pop_s  = valid_r & out_ready;
  assign push_s = wr_en & (~full_r | pop_s);
  assign drop_s = wr_en & full_r & ~pop_s;

  // Occupancy update.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Next output word: the new head if one remains, else the word just popped.
  always_comb begin
    salida_next_s = salida_r;
    if (pop_s) begin
      if (level_r > LW'(1)) begin
        salida_next_s = mem_r[rd_ptr_r + AW'(1)];
      end else if (push_s) begin
        salida_next_s = wr_data;
      end else begin
        salida_next_s = mem_r[rd_ptr_r];
      end
    end else if (push_s && !valid_r) begin
      salida_next_s = wr_data;
    end else begin
      salida_next_s = salida_r;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= wr_data;
  end

  // Pointers, occupancy, status flags and the registered output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      full_r     <= 1'b0;
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      salida_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r    <= level_next_s;
      full_r     <= (level_next_s == LW'(DEPTH));
      valid_r    <= (level_next_s != {LW{1'b0}});
      overflow_r <= overflow_r | drop_s;
      salida_r   <= salida_next_s;
    end
  end

  assign rd_data   = rd_data_s;
  assign wr_full   = full_r;
  assign out_valid = valid_r;
  assign salida    = salida_r;
  assign level     = level_r;
  assign overflow  = overflow_r;
endmodule

// File: tb/tb_cpu_io_ports.sv
// Bench for cpu_io_ports: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_cpu_io_ports;
  localparam int WIDTH = 16;
  localparam int NIN   = 4;
  localparam int DEPTH = 4;
  localparam int SW    = $clog2(NIN);
  localparam int LW    = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 reset;
  logic [NIN*WIDTH-1:0] p_in;
  logic [SW-1:0]        rd_sel;
  logic [WIDTH-1:0]     rd_data;
  logic                 wr_en;
  logic [WIDTH-1:0]     wr_data;
  logic                 wr_full;
  logic [WIDTH-1:0]     salida;
  logic                 out_valid;
  logic                 out_ready;
  logic [LW-1:0]        level;
  logic                 overflow;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_io_ports #(.WIDTH(WIDTH), .NIN(NIN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .p_in(p_in), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .salida(salida),
    .out_valid(out_valid), .out_ready(out_ready), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: samples, a FIFO queue, the last popped word, sticky overflow.
  logic [WIDTH-1:0] m_samp [NIN] = '{default: '0};
  logic [WIDTH-1:0] m_q [$];
  logic [WIDTH-1:0] m_last = '0;
  logic             m_ovf  = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NIN; k++) m_samp[k] = '0;
      m_q.delete();
      m_last = '0;
      m_ovf  = 1'b0;
    end else begin
      bit pop, full;
      pop  = (m_q.size() != 0) && out_ready;
      full = (m_q.size() == DEPTH);
      if (pop) m_last = m_q.pop_front();
      if (wr_en && (!full || pop)) m_q.push_back(wr_data);
      if (wr_en && full && !pop) m_ovf = 1'b1;
      for (int k = 0; k < NIN; k++) m_samp[k] = p_in[k*WIDTH +: WIDTH];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [WIDTH-1:0] e_rd;
    logic [WIDTH-1:0] e_sal;
    e_rd  = (int'(rd_sel) < NIN) ? m_samp[rd_sel] : '0;
    e_sal = (m_q.size() != 0) ? m_q[0] : m_last;
    chk("model rd_data",   32'(rd_data),   32'(e_rd));
    chk("model salida",    32'(salida),    32'(e_sal));
    chk("model out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("model wr_full",   32'(wr_full),   32'(m_q.size() == DEPTH));
    chk("model level",     32'(level),     32'(m_q.size()));
    chk("model overflow",  32'(overflow),  32'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write(input logic [WIDTH-1:0] v);
    wr_en   = 1'b1;
    wr_data = v;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; p_in = '0; rd_sel = '0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0;
    #1;
    chk("rst level",     32'(level),     32'd0);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst salida",    32'(salida),    32'd0);
    chk("rst overflow",  32'(overflow),  32'd0);
    chk("rst wr_full",   32'(wr_full),   32'd0);
    chk("rst rd_data",   32'(rd_data),   32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Input sampling
    p_in   = {16'h0000, 16'hBEEF, 16'h5678, 16'h1234};
    rd_sel = 2'd2;
    #1 chk("samp before edge", 32'(rd_data), 32'h0);
    tick();
    chk("samp ch2", 32'(rd_data), 32'hBEEF);
    rd_sel = 2'd3;
    #1 chk("samp ch3", 32'(rd_data), 32'h0);
    rd_sel = 2'd0;
    #1 chk("samp ch0", 32'(rd_data), 32'h1234);
    p_in[15:0] = 16'hAAAA;
    #1 chk("samp ch0 held", 32'(rd_data), 32'h1234);
    tick();
    chk("samp ch0 new", 32'(rd_data), 32'hAAAA);

    // Fill and drain
    out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) write(16'(v));
    chk("fill level",   32'(level),   32'd4);
    chk("fill wr_full", 32'(wr_full), 32'd1);
    chk("fill salida",  32'(salida),  32'd1);
    out_ready = 1'b1;
    for (int v = 2; v <= 4; v++) begin
      tick();
      chk("drain salida", 32'(salida), 32'(v));
    end
    tick();
    chk("drain empty valid", 32'(out_valid), 32'd0);
    chk("drain hold salida", 32'(salida),    32'd4);
    out_ready = 1'b0;

    // Overflow
    for (int v = 1; v <= 4; v++) write(16'(v));
    write(16'd5);
    chk("ovf flag",   32'(overflow), 32'd1);
    chk("ovf level",  32'(level),    32'd4);
    chk("ovf salida", 32'(salida),   32'd1);
    out_ready = 1'b1;
    for (int v = 2; v <= 4; v++) begin
      tick();
      chk("ovf drain", 32'(salida), 32'(v));
    end
    tick();
    chk("ovf drain empty", 32'(out_valid), 32'd0);
    chk("ovf drain last",  32'(salida),    32'd4);
    chk("ovf sticky",      32'(overflow),  32'd1);
    out_ready = 1'b0;
    tick();
    chk("ovf sticky idle", 32'(overflow), 32'd1);
    do_reset();
    chk("ovf cleared", 32'(overflow), 32'd0);

    // Push and pop on the same edge while full
    for (int v = 1; v <= 4; v++) write(16'(v));
    out_ready = 1'b1;
    write(16'd9);
    chk("pp level",    32'(level),    32'd4);
    chk("pp overflow", 32'(overflow), 32'd0);
    chk("pp salida",   32'(salida),   32'd2);
    tick(); chk("pp drain 3", 32'(salida), 32'd3);
    tick(); chk("pp drain 4", 32'(salida), 32'd4);
    tick(); chk("pp drain 9", 32'(salida), 32'd9);
    tick();
    chk("pp empty", 32'(out_valid), 32'd0);
    chk("pp last",  32'(salida),    32'd9);

    // Pointer wrap-around with push-then-pop pairs
    for (int v = 10; v <= 19; v++) begin
      write(16'(v));
      chk("wrap salida", 32'(salida), 32'(v));
      chk("wrap level",  32'(level),  32'd1);
      tick();
      chk("wrap popped", 32'(level),  32'd0);
      chk("wrap hold",   32'(salida), 32'(v));
    end

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int v = 21; v <= 24; v++) write(16'(v));
    write(16'd25);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("arst pre level", 32'(level),    32'd3);
    chk("arst pre ovf",   32'(overflow), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst level",    32'(level),     32'd0);
    chk("arst valid",    32'(out_valid), 32'd0);
    chk("arst salida",   32'(salida),    32'd0);
    chk("arst overflow", 32'(overflow),  32'd0);
    chk("arst rd_data",  32'(rd_data),   32'd0);
    reset = 1'b1;
    write(16'd7);
    chk("arst post salida", 32'(salida),    32'd7);
    chk("arst post valid",  32'(out_valid), 32'd1);
    chk("arst post level",  32'(level),     32'd1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
